// File: rtl/alu_bitslice_reg_if.sv
// Bundle of the execute-stage ALU signals: operands and op code in,
// registered result and flags out.
//
// Handshake: en is a one-way valid with no ready. The ALU accepts the
// operation presented on every rising edge where en=1; valid is en delayed
// by one cycle and marks the cycle in which result/flags reflect that new
// operation. While valid=0 the outputs keep their last values.
interface alu_bitslice_reg_if #(
    parameter int WIDTH = 64
);
    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic             valid;

    // Issuing side (decode/operand fetch).
    modport master (
        output en,
        output A,
        output B,
        output cntrl,
        input  result,
        input  negative,
        input  zero,
        input  overflow,
        input  carry_out,
        input  valid
    );

    // The ALU itself.
    modport slave (
        input  en,
        input  A,
        input  B,
        input  cntrl,
        output result,
        output negative,
        output zero,
        output overflow,
        output carry_out,
        output valid
    );
endinterface

// File: rtl/alu_bitslice_reg.sv
// Registered WIDTH-bit ALU built from a ripple chain of one-bit cells.
// Each cell holds a full adder, AND/OR logic, a 4:1 sum selector and a
// gated carry-out; a per-bit 2:1 mux feeds either B or ~B into the cell.
// Result and flags are captured one cycle after en is sampled high.
module alu_bitslice_reg #(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    alu_bitslice_reg_if.slave   bus
);

    // Op codes. 001 and 111 are reserved and produce an all-zero result.
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    // Cell sum selector encodings.
    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_PASS = 2'b10;
    localparam logic [1:0] SEL_SUM  = 2'b11;

    // Decoded control shared by every cell.
    logic       cout_sel;   // 1 gates every cell carry to 0
    logic [1:0] sum_sel;
    logic       sub;        // invert B and inject carry-in of 1
    logic       reserved;   // unassigned op code
    logic       arith;      // add or sub: flags from the carry chain

    // Datapath nets.
    logic [WIDTH-1:0] b_in;
    logic [WIDTH:0]   carry;    // carry[i] is the carry into bit i
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_negative;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry_out;

    // Output registers.
    logic [WIDTH-1:0] result_q;
    logic             negative_q;
    logic             zero_q;
    logic             overflow_q;
    logic             carry_out_q;
    logic             valid_q;

    // Op-code decode into cell controls; defaults describe a reserved op.
    always_comb begin
        cout_sel = 1'b1;
        sum_sel  = SEL_AND;
        sub      = 1'b0;
        reserved = 1'b0;
        arith    = 1'b0;
        unique case (bus.cntrl)
            OP_PASS: sum_sel = SEL_PASS;
            OP_ADD: begin
                sum_sel  = SEL_SUM;
                cout_sel = 1'b0;
                arith    = 1'b1;
            end
            OP_SUB: begin
                sum_sel  = SEL_SUM;
                cout_sel = 1'b0;
                sub      = 1'b1;
                arith    = 1'b1;
            end
            OP_AND:  sum_sel = SEL_AND;
            OP_OR:   sum_sel = SEL_OR;
            OP_XOR:  sum_sel = SEL_SUM;
            default: reserved = 1'b1;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the bit-0 carry-in.
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic a_bit;
        logic cell_b;
        logic cell_cin;
        logic cell_sum;
        logic cell_maj;

        assign a_bit    = bus.A[i];
        // 2:1 mux selecting B or ~B for this cell.
        assign cell_b   = sub ? ~bus.B[i] : bus.B[i];
        assign cell_cin = carry[i];
        assign b_in[i]  = cell_b;

        // Full-adder carry: majority of the three cell inputs.
        assign cell_maj = (a_bit & cell_b) | (a_bit & cell_cin) | (cell_b & cell_cin);

        // Carry-out is gated off for non-arithmetic ops so the chain stays quiet.
        assign carry[i+1] = cout_sel ? 1'b0 : cell_maj;

        // 4:1 sum selector for this cell.
        always_comb begin
            cell_sum = 1'b0;
            unique case (sum_sel)
                SEL_AND:  cell_sum = a_bit & cell_b;
                SEL_OR:   cell_sum = a_bit | cell_b;
                SEL_PASS: cell_sum = cell_b;
                SEL_SUM:  cell_sum = a_bit ^ cell_b ^ cell_cin;
                default:  cell_sum = 1'b0;
            endcase
        end

        assign sum[i] = cell_sum;
    end

    // Result and flag formation from the cell outputs.
    always_comb begin
        alu_result    = reserved ? '0 : sum;
        alu_negative  = alu_result[WIDTH-1];
        alu_zero      = (alu_result == '0);
        // Signed overflow: carry into the MSB disagrees with carry out of it.
        alu_overflow  = arith & (carry[WIDTH] ^ carry[WIDTH-1]);
        alu_carry_out = arith & carry[WIDTH];
    end

    // Output registers: reset wins over en, en captures, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q    <= '0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                result_q    <= alu_result;
                negative_q  <= alu_negative;
                zero_q      <= alu_zero;
                overflow_q  <= alu_overflow;
                carry_out_q <= alu_carry_out;
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.negative  = negative_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.carry_out = carry_out_q;
    assign bus.valid     = valid_q;

    // b_in is kept as a named bus for probing the B-path mux.
    logic unused_b_in;
    assign unused_b_in = ^b_in;

endmodule

// File: tb/tb_alu_bitslice_reg.sv
// Self-checking bench for alu_bitslice_reg (WIDTH=64): directed cases
// followed by randomized operations, compared against an arithmetic model.
module tb_alu_bitslice_reg;

    localparam int W = 64;
    // Expected packed as {result, negative, zero, overflow, carry_out}.
    localparam int EW = W + 4;

    logic clk;
    logic reset;

    alu_bitslice_reg_if #(.WIDTH(W)) bus ();

    alu_bitslice_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_bad    = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] last_exp;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        logic [W-1:0] r;
        logic         v;
        logic         c;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                r = a + b;
                c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        return {r, r[W-1], (r == '0), v, c};
    endfunction

    // Compare every output against a packed expectation.
    task automatic check_outputs(input string tag, input logic [EW-1:0] e, input logic exp_valid);
        check({tag, ".result"},    bus.result,          e[EW-1:4]);
        check({tag, ".negative"},  W'(bus.negative),    W'(e[3]));
        check({tag, ".zero"},      W'(bus.zero),        W'(e[2]));
        check({tag, ".overflow"},  W'(bus.overflow),    W'(e[1]));
        check({tag, ".carry_out"}, W'(bus.carry_out),   W'(e[0]));
        check({tag, ".valid"},     W'(bus.valid),       W'(exp_valid));
    endtask

    // ---------------- driver tasks ----------------
    // Issue one operation; check outputs #1 after the capturing edge.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op);
        @(negedge clk);
        bus.en    = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.cntrl = op;
        exp_q.push_back(model(a, b, op));
        @(posedge clk);
        #1;
        bus.en   = 1'b0;
        last_exp = exp_q.pop_front();
        check_outputs(tag, last_exp, 1'b1);
    endtask

    // Idle cycles with scrambled inputs: outputs must hold, valid low.
    task automatic idle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            bus.en    = 1'b0;
            bus.A     = {$urandom, $urandom};
            bus.B     = {$urandom, $urandom};
            bus.cntrl = 3'($urandom_range(0, 7));
            @(posedge clk);
            #1;
            check_outputs(tag, last_exp, 1'b0);
        end
    endtask

    localparam logic [EW-1:0] RESET_EXP = {{W{1'b0}}, 4'b0100};

    // ---------------- main sequence ----------------
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;

        reset     = 1'b1;
        bus.en    = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.cntrl = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        last_exp = RESET_EXP;
        check_outputs("reset", last_exp, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Add wrap.
        run_op("add_wrap", {W{1'b1}}, 64'd1, 3'b010);
        check("add_wrap.const", bus.result, 64'd0);
        check("add_wrap.cout",  W'(bus.carry_out), 64'd1);

        // Signed overflow on add.
        run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        check("add_ovf.const", bus.result, 64'h8000_0000_0000_0000);
        check("add_ovf.ovf",   W'(bus.overflow), 64'd1);

        // Subtract with and without borrow.
        run_op("sub_borrow", 64'd5, 64'd7, 3'b011);
        check("sub_borrow.const", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_borrow.cout",  W'(bus.carry_out), 64'd0);
        run_op("sub_noborrow", 64'd7, 64'd5, 3'b011);
        check("sub_noborrow.const", bus.result, 64'd2);
        check("sub_noborrow.cout",  W'(bus.carry_out), 64'd1);
        run_op("sub_equal", 64'd9, 64'd9, 3'b011);

        // Logic ops and pass.
        run_op("and", 64'hF0F0, 64'hFF00, 3'b100);
        check("and.const", bus.result, 64'hF000);
        run_op("or", 64'hF0F0, 64'hFF00, 3'b101);
        check("or.const", bus.result, 64'hFFF0);
        run_op("xor", 64'hF0F0, 64'hFF00, 3'b110);
        check("xor.const", bus.result, 64'h0FF0);
        run_op("pass", 64'hF0F0, 64'hFF00, 3'b000);
        check("pass.const", bus.result, 64'hFF00);

        // Reserved codes.
        run_op("rsv001", 64'hDEAD_BEEF_1234_5678, 64'hFFFF_0000_FFFF_0000, 3'b001);
        check("rsv001.zero", W'(bus.zero), 64'd1);
        run_op("rsv111", {W{1'b1}}, {W{1'b1}}, 3'b111);
        check("rsv111.zero", W'(bus.zero), 64'd1);

        // Hold after an add.
        run_op("hold_src", 64'h1234, 64'h8000_0000_0000_0000, 3'b010);
        idle("hold", 3);

        // Reset together with en discards the operation.
        @(negedge clk);
        reset     = 1'b1;
        bus.en    = 1'b1;
        bus.A     = 64'h55;
        bus.B     = 64'h66;
        bus.cntrl = 3'b010;
        @(posedge clk);
        #1;
        last_exp = RESET_EXP;
        check_outputs("reset_en", last_exp, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        bus.en = 1'b0;
        idle("post_reset", 1);

        // Randomized operations with occasional idle gaps.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0:       a = {W{1'b1}};
                1:       a = 64'h8000_0000_0000_0000;
                2:       a = 64'($urandom_range(0, 15));
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0:       b = {W{1'b1}};
                1:       b = 64'h7FFF_FFFF_FFFF_FFFF;
                2:       b = a;
                default: b = {$urandom, $urandom};
            endcase
            op = 3'($urandom_range(0, 7));
            run_op("rand", a, b, op);
            if ($urandom_range(0, 9) == 0) idle("rand_hold", int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_bitslice_reg.md
Name: alu_bitslice_reg

Overview:
- Registered WIDTH-bit ALU built from a ripple chain of one-bit ALU cells.
- Each cell contains a full adder, AND/OR logic, a 4:1 sum selector and a gated carry-out. A 2:1 mux per bit selects either B or ~B as the cell's B input.
- Decodes a 3-bit op code and produces the result plus negative, zero, overflow and carry_out flags, all registered.
- Sits in the CPU execute stage, feeding writeback and the flag register.

Parameters:
- WIDTH, 64, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  capture enable; operands are sampled when high.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cntrl  input  3  operation select.
- result  output  WIDTH  registered ALU result.
- negative  output  1  registered result[WIDTH-1].
- zero  output  1  registered; 1 when result is all zeros.
- overflow  output  1  registered signed overflow (add/sub only).
- carry_out  output  1  registered carry out of the MSB (add/sub only).
- valid  output  1  registered copy of en; high for the cycle in which outputs reflect a new operation.

Behaviour:
- Op codes:
  - 000 pass B
  - 010 A+B
  - 011 A-B
  - 100 A&B
  - 101 A|B
  - 110 A^B
  - 001 and 111 are reserved: result 0, negative 0, zero 1, overflow 0, carry_out 0.
- Cell per bit i: inputs a, b_in, cin, cout_sel, sum_sel[1:0]; outputs sum, cout.
  - sum_sel 00 gives a&b_in; 01 gives a|b_in; 10 gives b_in; 11 gives a^b_in^cin.
  - cout = majority(a, b_in, cin) when cout_sel=0; cout = 0 when cout_sel=1.
- Decode:
  - cout_sel = 0 only for 010/011.
  - sum_sel: 10 for pass, 11 for add/sub/xor, 00 for and, 01 for or.
  - sub = 1 only for 011.
- B path: b_in[i] = sub ? ~B[i] : B[i], via the 2:1 mux. Bit-0 cin = sub. The carry chain ripples from bit 0 to bit WIDTH-1.
- Subtraction is A + ~B + 1. carry_out=1 means no borrow (A >= B unsigned).
- overflow = carry into MSB XOR carry out of MSB, for add/sub only. Forced 0 for all other ops.
- carry_out = carry out of MSB for add/sub. Forced 0 otherwise.
- negative and zero are derived from the computed result for every op, including reserved codes.
- Latency: 1 cycle.
  - en=1 at edge N: outputs hold the op's values after edge N, and valid=1 for that cycle.
  - en=0: result and flags hold their previous values; valid=0.
- Reset (synchronous): on a rising edge with reset=1:
  - result=0, negative=0, zero=1, overflow=0, carry_out=0, valid=0.
  - Reset overrides en in the same cycle.
  - A reset asserted mid-stream discards the in-flight operation.
- Combinational logic has no state. Arithmetic wraps modulo 2^WIDTH.

Test Plan (WIDTH=64):
- Add wrap: A=0xFFFFFFFFFFFFFFFF, B=1, cntrl=010, en=1 -> next cycle: result=0, zero=1, carry_out=1, overflow=0, negative=0, valid=1.
- Signed overflow on add: A=0x7FFFFFFFFFFFFFFF, B=1, cntrl=010 -> result=0x8000000000000000, overflow=1, negative=1, carry_out=0.
- Subtract with borrow: A=5, B=7, cntrl=011 -> result=0xFFFFFFFFFFFFFFFE, negative=1, carry_out=0, overflow=0. Then A=7, B=5 -> result=2, carry_out=1.
- Logic ops, A=0xF0F0, B=0xFF00:
  - 100 -> 0xF000
  - 101 -> 0xFFF0
  - 110 -> 0x0FF0
  - 000 -> 0xFF00
  - For all four: carry_out=0, overflow=0.
- Reserved codes: cntrl=001 and cntrl=111 with nonzero operands -> result=0, zero=1, all other flags 0.
- Hold and reset:
  - en=0 for 3 cycles after an add -> outputs unchanged, valid=0.
  - reset=1 together with en=1 -> after the edge, result=0, zero=1, valid=0.
